rate_divider_multi: RTL and testbench

- Multi-channel programmable rate divider for the 50 MHz system clock.
- Each channel produces:
  - a one-cycle enable tick every DIV cycles;
  - a 50%-duty square wave that toggles on each tick.
- Drives frame-rate, movement-rate and animation timing in the maze renderer.
- Divisors are runtime-writable. A divisor change never produces a glitch or runt period.

---
 rtl/rate_div_pkg.sv | 16 +
 rtl/rate_div_channel.sv | 68 ++++++
 rtl/rate_divider_multi.sv | 43 ++++
 tb/tb_rate_divider_multi.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/rate_div_pkg.sv
// Shared clock/rate constants for the maze renderer's rate dividers.
// The optional phase-align input is enabled by defining RATE_DIV_SYNC_EN.
package rate_div_pkg;

  localparam int CLK_HZ = 50_000_000;

  function automatic int div_from_hz(input int hz);
    return CLK_HZ / hz;
  endfunction

  // DIV_1HZ needs a 26-bit counter; size CNT_W accordingly when using it.
  localparam int DIV_60HZ = div_from_hz(60);
  localparam int DIV_10HZ = div_from_hz(10);
  localparam int DIV_1HZ  = div_from_hz(1);

endpackage

// File: rtl/rate_div_channel.sv
// One divider channel: divisor register, down-counter, tick and square wave.
// sync_i exists only when RATE_DIV_SYNC_EN is defined.
module rate_div_channel
  import rate_div_pkg::*;
#(
  parameter int CNT_W       = 23,
  parameter int DEFAULT_DIV = DIV_60HZ
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             wr_stb_i,
  input  logic [CNT_W-1:0] wr_div_i,
`ifdef RATE_DIV_SYNC_EN
  input  logic             sync_i,
`endif
  output logic             tick_o,
  output logic             clkout_o
);

  logic [CNT_W-1:0] div_q, div_d, cnt_q, cnt_d;
  logic [CNT_W-1:0] src_div, reload;
  logic             tick_q, tick_d, clk_q, clk_d;

  always_comb begin
    // A write landing on a reload cycle feeds the reload directly.
    src_div = wr_stb_i ? wr_div_i : div_q;
    reload  = (src_div == '0) ? '0 : src_div - 1'b1;
    div_d   = src_div;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    clk_d   = clk_q;
    if (!en_i) begin
      cnt_d = reload;
    end
`ifdef RATE_DIV_SYNC_EN
    else if (sync_i) begin
      cnt_d = reload;
      clk_d = 1'b0;
    end
`endif
    else if (cnt_q == '0) begin
      cnt_d  = reload;
      tick_d = 1'b1;
      clk_d  = ~clk_q;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= CNT_W'(DEFAULT_DIV);
      cnt_q  <= CNT_W'(DEFAULT_DIV - 1);
      tick_q <= 1'b0;
      clk_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      clk_q  <= clk_d;
    end
  end

  assign tick_o   = tick_q;
  assign clkout_o = clk_q;

endmodule

// File: rtl/rate_divider_multi.sv
// Multi-channel programmable rate divider; ticks are clock enables, clkout is not a clock.
// Define RATE_DIV_SYNC_EN to add the sync phase-align input.
module rate_divider_multi
  import rate_div_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int CNT_W       = 23,
  parameter  int DEFAULT_DIV = DIV_60HZ,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clkin,
  input  logic              resetn,
  input  logic [NUM_CH-1:0] en,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
`ifdef RATE_DIV_SYNC_EN
  input  logic              sync,
`endif
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clkout
);

  // Out-of-range wr_ch matches no channel index, so such writes fall away.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    rate_div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_i    (clkin),
      .rst_ni   (resetn),
      .en_i     (en[c]),
      .wr_stb_i (wr_en && (wr_ch == CH_W'(c))),
      .wr_div_i (wr_div),
`ifdef RATE_DIV_SYNC_EN
      .sync_i   (sync),
`endif
      .tick_o   (tick[c]),
      .clkout_o (clkout[c])
    );
  end

endmodule

// File: tb/tb_rate_divider_multi.sv
// Self-checking bench for rate_divider_multi (small reset divisor to keep runs short).
module tb_rate_divider_multi;

  localparam int DEF = 40;

  logic        clkin = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  en = '0;
  logic [2:0]  en3 = '0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_ch = '0;
  logic [22:0] wr_div = '0;
  logic        sync = 1'b0;
  logic [3:0]  tick, clkout;
  logic [2:0]  tick3, clkout3;

  rate_divider_multi #(.NUM_CH(4), .CNT_W(23), .DEFAULT_DIV(DEF)) u_dut (
    .clkin(clkin), .resetn(resetn), .en(en), .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
`ifdef RATE_DIV_SYNC_EN
    .sync(sync),
`endif
    .tick(tick), .clkout(clkout));

  // Three-channel instance: wr_ch=3 is out of range here.
  rate_divider_multi #(.NUM_CH(3), .CNT_W(23), .DEFAULT_DIV(DEF)) u_dut3 (
    .clkin(clkin), .resetn(resetn), .en(en3), .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
`ifdef RATE_DIV_SYNC_EN
    .sync(1'b0),
`endif
    .tick(tick3), .clkout(clkout3));

  always #5 clkin = ~clkin;

  typedef struct { logic [3:0] t; logic [3:0] c; } exp_t;
  typedef struct { int ch; int div; int first; int period; } vec_t;

  exp_t q[$];
  vec_t tbl[5];
  int   tests = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected per-sample outputs: tick on `first`, then every `period` samples.
  task automatic push_exp(input logic [3:0] mask, input int first, input int period, input int n);
    int nt = 0;
    for (int j = 1; j <= n; j++) begin
      exp_t e;
      logic hit;
      hit = (j == first) || (j > first && ((j - first) % period) == 0);
      if (hit) nt++;
      e.t = hit ? mask : 4'h0;
      e.c = nt[0] ? mask : 4'h0;
      q.push_back(e);
    end
  endtask

  task automatic start(input logic [3:0] mask, input int wch, input int wdiv, input logic do_wr);
    @(negedge clkin);
    resetn = 1'b0; en = '0; en3 = '0;
    @(negedge clkin);
    resetn = 1'b1;
    if (do_wr) begin
      wr_en = 1'b1; wr_ch = 2'(wch); wr_div = 23'(wdiv);
      @(negedge clkin);
      wr_en = 1'b0;
    end
    en = mask;
  endtask

  // Pops one expectation per cycle; optionally writes after sample wr_at.
  task automatic run_seq(input string nm, input int n, input int wr_at, input int wch, input int wdiv);
    for (int j = 1; j <= n; j++) begin
      exp_t e;
      @(negedge clkin);
      if (q.size() == 0) begin
        chk({nm, "_queue"}, 32'd0, 32'd1);
      end else begin
        e = q.pop_front();
        chk({nm, "_tick"}, {28'd0, tick}, {28'd0, e.t});
        chk({nm, "_clkout"}, {28'd0, clkout}, {28'd0, e.c});
      end
      if (j == wr_at) begin
        wr_en = 1'b1; wr_ch = 2'(wch); wr_div = 23'(wdiv);
      end else begin
        wr_en = 1'b0;
      end
    end
    wr_en = 1'b0;
  endtask

  initial begin
    tbl[0] = '{ch: 1, div: 5,  first: 5,  period: 5};
    tbl[1] = '{ch: 3, div: 0,  first: 1,  period: 1};
    tbl[2] = '{ch: 3, div: 1,  first: 1,  period: 1};
    tbl[3] = '{ch: 0, div: 7,  first: 7,  period: 7};
    tbl[4] = '{ch: 2, div: 12, first: 12, period: 12};

    #3;
    chk("reset_tick", {28'd0, tick}, 32'd0);
    chk("reset_clkout", {28'd0, clkout}, 32'd0);
    chk("reset_tick3", {29'd0, tick3}, 32'd0);

    // Reset divisor on channel 0 only; others silent.
    start(4'b0001, 0, 0, 1'b0);
    push_exp(4'b0001, DEF, DEF, 2 * DEF + 5);
    run_seq("default", 2 * DEF + 5, 0, 0, 0);

    foreach (tbl[i]) begin
      logic [3:0] m;
      m = 4'b0001 << tbl[i].ch;
      start(m, tbl[i].ch, tbl[i].div, 1'b1);
      push_exp(m, tbl[i].first, tbl[i].period, 24);
      run_seq($sformatf("vec%0d", i), 24, 0, 0, 0);
    end

    // Mid-period write: old 10-cycle period completes, then period 3.
    start(4'b0100, 2, 10, 1'b1);
    push_exp(4'b0100, 10, 3, 25);
    run_seq("midwrite", 25, 5, 2, 3);

    // Write on the reload edge takes effect immediately.
    start(4'b0100, 2, 10, 1'b1);
    push_exp(4'b0100, 10, 3, 25);
    run_seq("reloadwrite", 25, 9, 2, 3);

    // Asynchronous reset mid-cycle, then divisors revert to the reset value.
    start(4'b1000, 3, 1, 1'b1);
    push_exp(4'b1000, 1, 1, 6);
    run_seq("prereset", 6, 0, 0, 0);
    @(posedge clkin); #2;
    chk("prereset_tick3", {31'd0, tick[3]}, 32'd1);
    chk("prereset_clk3", {31'd0, clkout[3]}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("async_tick", {28'd0, tick}, 32'd0);
    chk("async_clkout", {28'd0, clkout}, 32'd0);
    @(negedge clkin);
    resetn = 1'b1;
    en = 4'b1001;
    push_exp(4'b1001, DEF, DEF, DEF + 3);
    run_seq("postreset", DEF + 3, 0, 0, 0);

    // Out-of-range channel write on the 3-channel instance changes nothing.
    @(negedge clkin);
    resetn = 1'b0; en = '0; en3 = '0;
    @(negedge clkin);
    resetn = 1'b1;
    wr_en = 1'b1; wr_ch = 2'd3; wr_div = 23'd2;
    @(negedge clkin);
    wr_en = 1'b0;
    en3 = 3'b111;
    for (int j = 1; j <= DEF + 1; j++) begin
      @(negedge clkin);
      chk("oor_tick3", {29'd0, tick3}, (j == DEF) ? 32'd7 : 32'd0);
    end
    chk("oor_clkout3", {29'd0, clkout3}, 32'd7);
    en3 = '0;

`ifdef RATE_DIV_SYNC_EN
    start(4'b0000, 0, 7, 1'b1);
    wr_en = 1'b1; wr_ch = 2'd1; wr_div = 23'd11;
    @(negedge clkin);
    wr_en = 1'b0;
    en = 4'b0011;
    repeat (15) @(negedge clkin);
    sync = 1'b1;
    @(negedge clkin);
    sync = 1'b0;
    chk("sync_clkout", {30'd0, clkout[1:0]}, 32'd0);
    chk("sync_tick", {30'd0, tick[1:0]}, 32'd0);
    for (int j = 1; j <= 12; j++) begin
      @(negedge clkin);
      chk("sync_tick0", {31'd0, tick[0]}, (j == 7) ? 32'd1 : 32'd0);
      chk("sync_tick1", {31'd0, tick[1]}, (j == 11) ? 32'd1 : 32'd0);
    end
    chk("sync_clk0_end", {31'd0, clkout[0]}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
